// File: rtl/pc_redirect_unit_if.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit_if
// Purpose : groups the fetch-PC control inputs and the fetch-PC outputs of
//           pc_redirect_unit into one bundle.
// Signals :
//   stall_f          hold PC this cycle
//   pc_sel_d[1:0]    decode selection (1 = npc_d, others = PC+4)
//   npc_d            branch/jump target from decode
//   eret_m           eret in MEM, return to epc
//   epc              CP0 EPC
//   exc_req          exception/interrupt taken in MEM
//   pc_f             current fetch PC (registered)
//   pc4_f            pc_f + 4
//   flush_req        one-cycle flush pulse for younger stages
//   redirect_pending an M-stage redirect waits for stall release
//   fetch_adel       fetch address error (range-check builds only)
// Modports: master drives the controls and observes the PC (pipeline side),
//           slave is the redirect unit itself.
// -----------------------------------------------------------------------------
interface pc_redirect_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall_f;
    logic [1:0]       pc_sel_d;
    logic [WIDTH-1:0] npc_d;
    logic             eret_m;
    logic [WIDTH-1:0] epc;
    logic             exc_req;
    logic [WIDTH-1:0] pc_f;
    logic [WIDTH-1:0] pc4_f;
    logic             flush_req;
    logic             redirect_pending;
    logic             fetch_adel;

    modport master (
        output stall_f, pc_sel_d, npc_d, eret_m, epc, exc_req,
        input  pc_f, pc4_f, flush_req, redirect_pending, fetch_adel
    );

    modport slave (
        input  stall_f, pc_sel_d, npc_d, eret_m, epc, exc_req,
        output pc_f, pc4_f, flush_req, redirect_pending, fetch_adel
    );
endinterface : pc_redirect_unit_if

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
// Purpose : fetch-stage PC register with prioritised next-PC selection
//           (exception > eret > latched redirect > decode target > PC+4).
//           M-stage redirects that arrive while fetch is stalled are latched
//           in a pending register so they survive the stall.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    pc_redirect_unit_if.slave (controls in, fetch PC / status out)
// Config  : define PC_RANGE_CHECK_EN to drive fetch_adel from a range and
//           alignment check of pc_f against PC_LO..PC_HI; otherwise
//           fetch_adel is tied low and no comparators are built.
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [WIDTH-1:0] PC_LO      = 32'h0000_3000,
    parameter logic [WIDTH-1:0] PC_HI      = 32'h0000_6ffc
) (
    input  logic                clk,
    input  logic                reset,
    pc_redirect_unit_if.slave   bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    typedef enum logic {
        KIND_EXC  = 1'b0,
        KIND_ERET = 1'b1
    } kind_e;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    state_e           state_q,  state_d;
    kind_e            pend_kind_q, pend_kind_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             fetch_adel_s;

    // Elaboration-time sanity check: the reset PC must be a legal fetch address.
    if ((RESET_PC < PC_LO) || (RESET_PC > PC_HI)) begin : g_bad_reset_pc
        $error("pc_redirect_unit: RESET_PC outside PC_LO..PC_HI");
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d       = state_q;
        pend_kind_d   = pend_kind_q;
        pend_target_d = pend_target_q;
        pc_d          = pc_q;
        flush_d       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!bus.stall_f) begin
                    if (bus.exc_req) begin
                        pc_d    = EXC_VECTOR;
                        flush_d = 1'b1;
                    end else if (bus.eret_m) begin
                        pc_d    = bus.epc;
                        flush_d = 1'b1;
                    end else if (bus.pc_sel_d == 2'd1) begin
                        pc_d = bus.npc_d;
                    end else begin
                        // Reserved selections 2/3 fall back to sequential fetch.
                        pc_d = pc_q + PC_STEP;
                    end
                end else begin
                    // Stalled: PC holds; decode will re-present its selection,
                    // but an M-stage redirect must be remembered.
                    if (bus.exc_req) begin
                        pend_kind_d   = KIND_EXC;
                        pend_target_d = EXC_VECTOR;
                        state_d       = ST_PEND;
                    end else if (bus.eret_m) begin
                        pend_kind_d   = KIND_ERET;
                        pend_target_d = bus.epc;
                        state_d       = ST_PEND;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_PEND: begin
                if (bus.stall_f) begin
                    // An exception always supersedes; an eret may only replace
                    // an older eret, never a pending exception.
                    if (bus.exc_req) begin
                        pend_kind_d   = KIND_EXC;
                        pend_target_d = EXC_VECTOR;
                    end else if (bus.eret_m && (pend_kind_q == KIND_ERET)) begin
                        pend_target_d = bus.epc;
                    end else begin
                        pend_target_d = pend_target_q;
                    end
                end else begin
                    // Release: same-cycle M redirects are younger and win.
                    if (bus.exc_req) begin
                        pc_d = EXC_VECTOR;
                    end else if (bus.eret_m) begin
                        pc_d = bus.epc;
                    end else begin
                        pc_d = pend_target_q;
                    end
                    flush_d       = 1'b1;
                    state_d       = ST_RUN;
                    pend_kind_d   = KIND_EXC;
                    pend_target_d = '0;
                end
            end

            default: begin
                state_d       = ST_RUN;
                pend_kind_d   = KIND_EXC;
                pend_target_d = '0;
            end
        endcase
    end

    // State, pending redirect, PC and flush registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pend_kind_q   <= KIND_EXC;
            pend_target_q <= '0;
            pc_q          <= RESET_PC;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
        end
    end

`ifdef PC_RANGE_CHECK_EN
    // Misaligned or out-of-window fetch address; PC still advances normally.
    always_comb begin
        fetch_adel_s = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    end
`else
    // Range check not built.
    always_comb begin
        fetch_adel_s = 1'b0;
    end
`endif

    assign bus.pc_f             = pc_q;
    assign bus.pc4_f            = pc_q + PC_STEP;
    assign bus.flush_req        = flush_q;
    assign bus.redirect_pending = (state_q == ST_PEND);
    assign bus.fetch_adel       = fetch_adel_s;

endmodule : pc_redirect_unit

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-stage program-counter register with prioritised next-PC selection for the pipelined MIPS core. Chooses among sequential PC+4, decode-stage branch/jump target, eret return (EPC) and exception entry vector, honours fetch stalls, and latches M-stage redirects that arrive during a stall so they are never lost. Sits at the head of IF, feeding instruction memory and the F/D pipeline register.

## Interface
Parameters:
- WIDTH, 32, address width
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address
- PC_LO, 32'h0000_3000, lowest legal fetch address (range check only)
- PC_HI, 32'h0000_6ffc, highest legal fetch address (range check only)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_f  in  1  hold PC this cycle
- pc_sel_d  in  2  decode selection: 0 = PC+4, 1 = npc_d, 2/3 reserved (treated as 0)
- npc_d  in  WIDTH  branch/jump target from decode
- eret_m  in  1  eret in MEM; return to epc
- epc  in  WIDTH  CP0 EPC
- exc_req  in  1  exception/interrupt taken in MEM
- pc_f  out  WIDTH  current fetch PC (registered)
- pc4_f  out  WIDTH  pc_f + 4
- flush_req  out  1  one-cycle pulse: younger stages must flush
- redirect_pending  out  1  an M-stage redirect is latched awaiting stall release
- fetch_adel  out  1  fetch address error (PC_RANGE_CHECK_EN only; else tied 0)

## Operation
- States: RUN, PEND. Pending register holds {kind, target}; kind ∈ {EXC, ERET}.
- Source priority each cycle: exc_req > eret_m > pending > pc_sel_d==1 > PC+4.
- RUN, stall_f=0: pc_f ← highest-priority target. exc_req → EXC_VECTOR; eret_m → epc (sampled this cycle); else pc_sel_d.
- RUN, stall_f=1, exc_req or eret_m: pc_f holds; target captured into pending; → PEND.
- RUN, stall_f=1, no M redirect: pc_f holds; pc_sel_d ignored (decode re-presents it).
- PEND, stall_f=1: pc_f holds. New exc_req overwrites pending (kind EXC). New eret_m ignored while pending kind is EXC; overwrites if pending is ERET.
- PEND, stall_f=0: new exc_req/eret_m in same cycle win over pending; otherwise pc_f ← pending target. → RUN, pending cleared. pc_sel_d ignored in this cycle.
- Simultaneous exc_req and eret_m: exc_req wins, eret dropped.
- pc4_f = pc_f + 4 modulo 2^WIDTH (wraps silently).
- redirect_pending = (state == PEND).

## Timing
- Reset values: pc_f = RESET_PC, state RUN, pending cleared, flush_req = 0, redirect_pending = 0, fetch_adel = 0 (RESET_PC assumed legal).
- Latency: selection in cycle N visible on pc_f in N+1.
- flush_req is registered: high exactly in the first cycle pc_f shows an EXC_VECTOR or epc target (direct or from pending); low otherwise, including branch redirects.
- Reset asserted in any state (incl. PEND) overrides all inputs in that cycle; pending redirect discarded.
- pc4_f, redirect_pending, fetch_adel are combinational from registers only (no input-to-output paths).

## Configuration
- PC_RANGE_CHECK_EN defined: fetch_adel = 1 when pc_f[1:0] != 0, pc_f < PC_LO, or pc_f > PC_HI; PC still advances normally (exception raised downstream).
- Not defined: fetch_adel tied 0, no comparators, PC_LO/PC_HI unused.

## Test plan
- Reset, then 3 cycles with pc_sel_d=0, no stall -> pc_f 0x3000, 0x3004, 0x3008, 0x300c; flush_req stays 0.
- pc_sel_d=1, npc_d=0x3100 at pc_f=0x3004 -> next pc_f=0x3100, flush_req 0; same with stall_f=1 -> pc_f holds 0x3004.
- stall_f=1 three cycles, eret_m=1 with epc=0x3200 in first -> redirect_pending 1 for stalled cycles, pc_f holds; stall drops -> pc_f=0x3200 next cycle with flush_req=1 one cycle, pending 0.
- exc_req and eret_m same cycle (epc=0x3200), no stall -> pc_f=0x4180, flush_req=1; in PEND(ERET) exc_req arrives -> released target 0x4180.
- Reset asserted while PEND -> pc_f=0x3000, redirect_pending 0, flush_req 0 next cycle.
- With PC_RANGE_CHECK_EN: npc_d=0x3002 -> fetch_adel 1; npc_d=0x7000 -> fetch_adel 1; without macro both -> 0.
